adder_8b: RTL and testbench

// - Registered unsigned adder with valid qualifier: sums two DATA_W-bit operands per valid beat.
// - Emits a DATA_W+1-bit result with its own valid strobe, LATENCY cycles after input.
// - Leaf datapath block driven from the team's standard stream-style interface bundle.
// - No back-pressure.

---
 rtl/adder_pkg.sv | 17 +
 rtl/vld_pipe.sv | 37 +++
 rtl/adder_8b.sv | 40 ++++
 tb/tb_adder_8b.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and limits for the registered adder.
package adder_pkg;

  localparam int DATA_W      = 8;
  localparam int LATENCY_MAX = 4;

  typedef logic [DATA_W-1:0] operand_t;
  typedef logic [DATA_W:0]   result_t;

  // Keep the requested latency inside the supported 1..LATENCY_MAX window.
  function automatic int clamp_latency(input int lat);
    if (lat < 1)           return 1;
    if (lat > LATENCY_MAX) return LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/vld_pipe.sv
// Generic {valid, data} shift register.
// Data registers load only when the upstream stage is valid, so the tail holds
// the last valid word across bubbles. A synchronous clear empties every stage.
module vld_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH:1]            vld_sr;
  logic [DEPTH:1][WIDTH-1:0] data_sr;

  // Advance valid bits every cycle; move data only behind a valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr  <= '0;
      data_sr <= '0;
    end else begin
      vld_sr[1] <= in_vld;
      if (in_vld) data_sr[1] <= in_data;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        if (vld_sr[i-1]) data_sr[i] <= data_sr[i-1];
      end
    end
  end

  assign out_vld  = vld_sr[DEPTH];
  assign out_data = data_sr[DEPTH];

endmodule

// File: rtl/adder_8b.sv
// Registered unsigned adder with valid qualifier.
// The full-width sum (carry in the MSB) is formed combinationally and carried
// through a valid-gated pipeline of LATENCY stages.
module adder_8b
  import adder_pkg::*;
#(
  parameter int DATA_W  = adder_pkg::DATA_W,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,        // active-high synchronous reset
  input  logic              data_in_vld,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  output logic              data_out_vld,
  output logic [DATA_W:0]   data_out
);

  localparam int DEPTH = clamp_latency(LATENCY);

  logic [DATA_W:0] sum;

  // Zero-extend both operands so the carry-out lands in the result MSB.
  always_comb begin
    sum = {1'b0, data_in0} + {1'b0, data_in1};
  end

  vld_pipe #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst_n),
    .in_vld   (data_in_vld),
    .in_data  (sum),
    .out_vld  (data_out_vld),
    .out_data (data_out)
  );

endmodule

// File: tb/tb_adder_8b.sv
// Scoreboard bench for adder_8b: stimulus pushes {expected sum, due cycle},
// an independent monitor checks every output cycle against the queue.
module tb_adder_8b;

  localparam int LAT = 1;

  typedef struct packed {
    logic [8:0] sum;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       data_in_vld = 1'b0;
  logic [7:0] data_in0 = '0;
  logic [7:0] data_in1 = '0;
  logic       data_out_vld;
  logic [8:0] data_out;

  exp_t       sb[$];
  int         cyc = 0;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic       rst_seen = 1'b1;
  logic       started = 1'b0;
  logic [8:0] last = '0;
  logic       done = 1'b0;

  adder_8b #(.DATA_W(8), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in_vld  (data_in_vld),
    .data_in0     (data_in0),
    .data_in1     (data_in1),
    .data_out_vld (data_out_vld),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
    started  <= 1'b1;
  end

  task automatic check(input string name, input logic ok, input logic [8:0] act, input logic [8:0] req);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
  endtask

  // Monitor: compares every sampled cycle against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (done) break;
      if (!started) continue;
      if (rst_seen) begin
        check("reset_vld", data_out_vld == 1'b0, {8'h0, data_out_vld}, 9'h0);
        check("reset_data", data_out == 9'h0, data_out, 9'h0);
        last = '0;
        continue;
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        check("missed_strobe", 1'b0, 9'h0, sb[0].sum);
        void'(sb.pop_front());
      end
      if (data_out_vld) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          check("unexpected_strobe", 1'b0, data_out, (sb.size() > 0) ? sb[0].sum : 9'h0);
        end else begin
          check("sum", data_out == sb[0].sum, data_out, sb[0].sum);
          void'(sb.pop_front());
        end
        last = data_out;
      end else begin
        check("hold", data_out == last, data_out, last);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
    exp_t e;
    @(posedge clk); #1;
    data_in_vld = 1'b1;
    data_in0    = a;
    data_in1    = b;
    e.sum = exp;
    e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      data_in_vld = 1'b0;
      data_in0    = 8'($urandom);
      data_in1    = 8'($urandom);
    end
  endtask

  initial begin
    logic [7:0] a, b;
    // Reset held with live random traffic; monitor requires zeros throughout.
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      data_in_vld = 1'b1;
      data_in0    = 8'($urandom);
      data_in1    = 8'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    data_in_vld = 1'b0;
    idle(2);

    // Basic and carry corners.
    send(8'h12, 8'h34, 9'h046);
    idle(3);
    send(8'hFF, 8'hFF, 9'h1FE);
    send(8'hFF, 8'h01, 9'h100);
    send(8'h00, 8'h00, 9'h000);
    idle(3);

    // Ten back-to-back beats.
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      send(a, b, {1'b0, a} + {1'b0, b});
    end
    idle(2);

    // Gap pattern 1,0,0,1; data_out must hold through the gaps.
    send(8'h7F, 8'h01, 9'h080);
    idle(2);
    send(8'hA5, 8'h5A, 9'h0FF);
    idle(3);

    // Reset while beats are in flight.
    send(8'h11, 8'h22, 9'h033);
    send(8'h33, 8'h44, 9'h077);
    send(8'h55, 8'h66, 9'h0BB);
    @(posedge clk); #1;
    rst_n = 1'b1;
    data_in_vld = 1'b1;
    data_in0 = 8'hEE;
    data_in1 = 8'hEE;
    @(posedge clk);
    sb.delete();
    #1;
    data_in0 = 8'hCC;
    @(posedge clk); #1;
    rst_n = 1'b0;
    data_in_vld = 1'b0;
    send(8'h80, 8'h80, 9'h100);
    idle(LAT + 3);

    @(posedge clk); #1;
    done = 1'b1;
    check("sb_empty", sb.size() == 0, 9'(sb.size()), 9'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
